dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequencer for the data SRAM port used by the MEM stage. It accepts one load or store per instruction from EX and generates byte-lane enables and replicated write data. It waits on a variable-latency SRAM ready handshake and holds the pipeline through a stall request. It returns aligned, sign- or zero-extended load data for writeback and forwarding, and flags misaligned or timed-out accesses.

Parameters:
WAIT_MAX, 16, maximum ACCESS cycles without data_sram_ready before timeout (>=1).
CNT_W, 5, width of the wait counter; must hold WAIT_MAX.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  EX presents a memory instruction this cycle
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as misaligned
req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
mem_adv  in  1  pipeline allows MEM to advance (stall[3]==NoStop)
data_sram_en  out  1  SRAM enable, registered
data_sram_wen  out  4  byte write enables, registered
data_sram_addr  out  32  word-aligned address ({addr[31:2],2'b00}), registered
data_sram_wdata  out  32  lane-replicated store data, registered
data_sram_rdata  in  32  SRAM read data, valid when data_sram_ready=1
data_sram_ready  in  1  SRAM completion strobe
stallreq_mem  out  1  request pipeline stall
load_data  out  32  extended load result
result_valid  out  1  load_data/completion valid this cycle
addr_err  out  1  misaligned/illegal access pulse
bus_err  out  1  timeout completion flag

Behaviour:
- States: IDLE, ACCESS, DONE. Reset: state=IDLE. Every output register is cleared to 0 on reset, including en, wen, addr, wdata, load_data, result_valid, bus_err and the counter.
- Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=3.
- In IDLE, if req_valid is high and the access is misaligned:
  - addr_err=1 combinationally that cycle.
  - No SRAM access is issued, no stall is requested, and the state stays IDLE.
- In IDLE, if req_valid is high and the access is aligned:
  - At the next edge, register en=1, addr, wen and wdata, clear the counter, and go to ACCESS.
- Lane rules (little-endian, a=addr[1:0]):
  - Byte: wen=4'b0001<<a, wdata={4{d[7:0]}}.
  - Half: wen=4'b0011<<a, wdata={2{d[15:0]}}.
  - Word: wen=4'b1111, wdata=d.
  - Loads: wen=4'b0000.
- In ACCESS:
  - en stays at 1 and the counter increments each cycle.
  - On data_sram_ready=1, the next edge captures the extracted load data, drops en/wen to 0 and goes to DONE.
  - Extraction for a load: byte = rdata[8a+7:8a], extended from its bit 7; half = rdata[8a+15:8a], extended from its bit 15; word = rdata.
  - Stores write load_data=0.
  - If the counter reaches WAIT_MAX-1 with no ready, go to DONE with bus_err=1 and load_data=0, and drop en.
- stallreq_mem = (IDLE & req_valid & aligned) | ACCESS. It is combinational and has no bubble on entry.
- In DONE:
  - stallreq_mem=0 and result_valid=1; load_data and bus_err are held.
  - If mem_adv=1, the next edge goes to IDLE and clears result_valid and bus_err.
  - Otherwise the state stays DONE and outputs are held.
- Request latches are ignored outside IDLE. EX holds them stable while stalled.
- data_sram_ready outside ACCESS is ignored.
- Reset in any state: the next edge goes to IDLE with en=0, and the in-flight access is abandoned without a result.
- Minimum latency with ready in the first ACCESS cycle: request at cycle 0, en at cycle 1, result_valid at cycle 2.

Decomposition:
- Add to defines.vh:
  - size codes SZ_B/SZ_H/SZ_W;
  - state encodings ST_IDLE/ST_ACCESS/ST_DONE;
  - Stop/NoStop, already present.
- One natural sub-module, dmem_lane_align: purely combinational wen/wdata generation and load extraction/extension, shared with any future uncached path.

Test Plan:
- sw addr=0x100 wdata=0x11223344, ready on 1st ACCESS cycle -> cycle1: en=1, wen=1111, addr=0x100, wdata=0x11223344; stallreq high cycles 0–1; result_valid cycle 2.
- sb addr=0x103 wdata=0x000000AB -> wen=1000, wdata=0xABABABAB.
- lb addr=0x102, rdata=0x1280FF00 -> load_data=0xFFFFFF80; lbu -> 0x00000080; lh addr=0x102 -> 0x00001280.
- lw with ready delayed 5 cycles and mem_adv=0 for 3 cycles in DONE -> stallreq high 6 cycles; result_valid held 3 cycles, then IDLE.
- lh addr=0x101 -> addr_err=1 that cycle, en never asserts, stallreq=0; WAIT_MAX=4 with no ready -> bus_err=1, load_data=0 after 4 ACCESS cycles.
- rst asserted mid-ACCESS -> next cycle en=0, state IDLE, stallreq=0; later ready pulse ignored.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data SRAM sequencer: size codes, FSM states,
// stall codes and the latched-request record.
package dmem_access_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Fields of the accepted request needed later to extract the load result.
  typedef struct packed {
    logic       we;
    logic       sgn;
    logic [1:0] size;
    logic [1:0] off;
  } req_lat_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replicated data on the request side, and load
// byte/half/word extraction with sign or zero extension on the response side.
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  wen,
  output logic [31:0] wdata,
  input  logic        rsp_we,
  input  logic [1:0]  rsp_size,
  input  logic [1:0]  rsp_off,
  input  logic        rsp_signed,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [15:0] rshift;

  assign rshift = 16'(rdata >> {rsp_off, 3'b000});

  always_comb begin
    wen   = 4'b0000;
    wdata = req_wdata;
    case (req_size)
      SZ_B: begin
        wen   = 4'b0001 << req_off;
        wdata = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        wen   = 4'b0011 << req_off;
        wdata = {2{req_wdata[15:0]}};
      end
      SZ_W:    wen = 4'b1111;
      default: wen = 4'b0000;
    endcase
    if (!req_we) wen = 4'b0000;
  end

  always_comb begin
    rdata_ext = rdata;
    case (rsp_size)
      SZ_B:    rdata_ext = {{24{rsp_signed & rshift[7]}}, rshift[7:0]};
      SZ_H:    rdata_ext = {{16{rsp_signed & rshift[15]}}, rshift};
      default: rdata_ext = rdata;
    endcase
    if (rsp_we) rdata_ext = 32'd0;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data SRAM sequencer: issues one access per request, waits for ready with
// a timeout, stalls the pipeline meanwhile, and returns the extended load result.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        mem_adv,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_ready,
  output logic        stallreq_mem,
  output logic [31:0] load_data,
  output logic        result_valid,
  output logic        addr_err,
  output logic        bus_err
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_lat_t         lat_q, lat_d;
  logic             en_d;
  logic [3:0]       wen_d;
  logic [31:0]      addr_d, wdata_d, load_d;
  logic             rv_d, berr_d;

  logic             idle_req, mis, req_ok;
  logic [3:0]       lane_wen;
  logic [31:0]      lane_wdata, ext_data;

  assign idle_req     = (state_q == ST_IDLE) && req_valid;
  assign mis          = is_misaligned(req_size, req_addr[1:0]);
  assign req_ok       = idle_req && !mis;
  assign addr_err     = idle_req && mis;
  // Combinational so the stall covers the request cycle itself.
  assign stallreq_mem = req_ok || (state_q == ST_ACCESS);

  dmem_lane_align u_lane_align (
    .req_we     (req_we),
    .req_size   (req_size),
    .req_off    (req_addr[1:0]),
    .req_wdata  (req_wdata),
    .wen        (lane_wen),
    .wdata      (lane_wdata),
    .rsp_we     (lat_q.we),
    .rsp_size   (lat_q.size),
    .rsp_off    (lat_q.off),
    .rsp_signed (lat_q.sgn),
    .rdata      (data_sram_rdata),
    .rdata_ext  (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    en_d    = data_sram_en;
    wen_d   = data_sram_wen;
    addr_d  = data_sram_addr;
    wdata_d = data_sram_wdata;
    load_d  = load_data;
    rv_d    = result_valid;
    berr_d  = bus_err;
    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          en_d    = 1'b1;
          wen_d   = lane_wen;
          addr_d  = {req_addr[31:2], 2'b00};
          wdata_d = lane_wdata;
          lat_d   = '{we: req_we, sgn: req_signed, size: req_size, off: req_addr[1:0]};
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (data_sram_ready) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          wen_d   = 4'b0000;
          load_d  = ext_data;
          rv_d    = 1'b1;
          berr_d  = 1'b0;
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          wen_d   = 4'b0000;
          load_d  = 32'd0;
          rv_d    = 1'b1;
          berr_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (mem_adv) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
          berr_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      lat_q           <= '0;
      data_sram_en    <= 1'b0;
      data_sram_wen   <= 4'b0000;
      data_sram_addr  <= 32'd0;
      data_sram_wdata <= 32'd0;
      load_data       <= 32'd0;
      result_valid    <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      lat_q           <= lat_d;
      data_sram_en    <= en_d;
      data_sram_wen   <= wen_d;
      data_sram_addr  <= addr_d;
      data_sram_wdata <= wdata_d;
      load_data       <= load_d;
      result_valid    <= rv_d;
      bus_err         <= berr_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: expected results are queued when a request
// is issued and popped when result_valid appears.
module tb_dmem_access_ctrl;

  localparam int WAIT_MAX = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_signed, mem_adv;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        data_sram_en, data_sram_ready;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        stallreq_mem, result_valid, addr_err, bus_err;
  logic [31:0] load_data;

  typedef struct {
    logic [31:0] ld;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .mem_adv         (mem_adv),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .data_sram_ready (data_sram_ready),
    .stallreq_mem    (stallreq_mem),
    .load_data       (load_data),
    .result_valid    (result_valid),
    .addr_err        (addr_err),
    .bus_err         (bus_err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_adv = 1'b1;
    data_sram_ready = 1'b0; data_sram_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, load_data,
         result_valid, bus_err, stallreq_mem, addr_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b wen=%b addr=%h wdata=%h ld=%h rv=%b be=%b st=%b ae=%b expected all 0",
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, load_data,
               result_valid, bus_err, stallreq_mem, addr_err);
    end
  endtask

  // ready_cyc: ACCESS cycle (1-based) carrying ready, 0 = never. exp_lat: cycle of result_valid.
  task automatic run_access(input string nm, input logic we, input logic [1:0] sz,
                            input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int ready_cyc, input int hold_cyc,
                            input logic [3:0] exp_wen, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_ld, input logic exp_berr, input int exp_lat);
    int   stalls;
    int   cyc;
    bit   seen;
    exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = a; req_wdata = wd; mem_adv = (hold_cyc == 0);
    sb.push_back('{ld: exp_ld, berr: exp_berr});
    @(negedge clk);
    stalls = int'(stallreq_mem);
    checks++;
    if (addr_err !== 1'b0 || stallreq_mem !== 1'b1) begin
      errors++;
      $display("FAIL %s req_cycle: addr_err=%b stallreq=%b expected 0/1", nm, addr_err, stallreq_mem);
    end
    seen = 0;
    for (cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      data_sram_ready = (cyc == ready_cyc);
      data_sram_rdata = (cyc == ready_cyc) ? rd : 32'hDEAD_BEEF;
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if (data_sram_en !== 1'b1 || data_sram_wen !== exp_wen ||
            data_sram_addr !== {a[31:2], 2'b00} || data_sram_wdata !== exp_wdata) begin
          errors++;
          $display("FAIL %s issue: en=%b wen=%b addr=%h wdata=%h expected 1 %b %h %h", nm,
                   data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                   exp_wen, {a[31:2], 2'b00}, exp_wdata);
        end
      end
      stalls += int'(stallreq_mem);
      if (result_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (cyc != exp_lat) begin
          errors++;
          $display("FAIL %s latency: result at cycle %0d expected %0d", nm, cyc, exp_lat);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard: result with no expected entry", nm);
        end else begin
          e = sb.pop_front();
          if (load_data !== e.ld || bus_err !== e.berr || data_sram_en !== 1'b0) begin
            errors++;
            $display("FAIL %s result: load_data=%h bus_err=%b en=%b expected %h %b 0", nm,
                     load_data, bus_err, data_sram_en, e.ld, e.berr);
          end
        end
      end
    end
    data_sram_ready = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: result_valid never seen within 40 cycles", nm);
    end else if (stalls != exp_lat) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stalls, exp_lat);
    end
    for (int h = 1; h <= hold_cyc; h++) begin
      @(posedge clk); #1;
      if (h == hold_cyc) mem_adv = 1'b1;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || stallreq_mem !== 1'b0 || load_data !== exp_ld) begin
        errors++;
        $display("FAIL %s done_hold%0d: rv=%b stall=%b ld=%h expected 1 0 %h", nm, h,
                 result_valid, stallreq_mem, load_data, exp_ld);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || bus_err !== 1'b0 || stallreq_mem !== 1'b0) begin
      errors++;
      $display("FAIL %s release: rv=%b bus_err=%b stall=%b expected 0 0 0", nm,
               result_valid, bus_err, stallreq_mem);
    end
  endtask

  task automatic test_stores();
    run_access("sw", 1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344, 32'h0, 1, 0,
               4'b1111, 32'h1122_3344, 32'h0, 1'b0, 2);
    run_access("sb", 1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AB, 32'h0, 1, 0,
               4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0, 2);
    run_access("sh", 1'b1, 2'd1, 1'b0, 32'h202, 32'hFFFF_1234, 32'h0, 2, 0,
               4'b1100, 32'h1234_1234, 32'h0, 1'b0, 3);
  endtask

  task automatic test_loads();
    run_access("lb", 1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 32'h1280_FF00, 1, 0,
               4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    run_access("lbu", 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h1280_FF00, 1, 0,
               4'b0000, 32'h0, 32'h0000_0080, 1'b0, 2);
    run_access("lh", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h1280_FF00, 1, 0,
               4'b0000, 32'h0, 32'h0000_1280, 1'b0, 2);
    run_access("lh_neg", 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h1280_FF00, 1, 0,
               4'b0000, 32'h0, 32'hFFFF_FF00, 1'b0, 2);
    run_access("lbu_lane1", 1'b0, 2'd0, 1'b0, 32'h301, 32'h0, 32'h12C3_4567, 1, 0,
               4'b0000, 32'h0, 32'h0000_0045, 1'b0, 2);
  endtask

  task automatic test_wait_and_hold();
    run_access("lw_slow", 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'hCAFE_F00D, 5, 3,
               4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0, 6);
  endtask

  task automatic test_timeout();
    run_access("lw_timeout", 1'b0, 2'd2, 1'b1, 32'h108, 32'h0, 32'h8765_4321, 0, 0,
               4'b0000, 32'h0, 32'h0, 1'b1, WAIT_MAX + 1);
  endtask

  task automatic test_misaligned();
    logic [1:0]  szs[3];
    logic [31:0] adrs[3];
    szs = '{2'd1, 2'd2, 2'd3};
    adrs = '{32'h101, 32'h102, 32'h100};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = szs[i]; req_addr = adrs[i];
      @(negedge clk);
      checks++;
      if (addr_err !== 1'b1 || stallreq_mem !== 1'b0) begin
        errors++;
        $display("FAIL misaligned%0d: addr_err=%b stall=%b expected 1 0", i, addr_err, stallreq_mem);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (data_sram_en !== 1'b0 || addr_err !== 1'b0 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL misaligned%0d_noissue: en=%b addr_err=%b rv=%b expected 0 0 0", i,
                 data_sram_en, addr_err, result_valid);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (data_sram_en !== 1'b0 || stallreq_mem !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: en=%b stall=%b rv=%b expected 0 0 0", data_sram_en,
               stallreq_mem, result_valid);
    end
    @(posedge clk); #1;
    data_sram_ready = 1'b1; data_sram_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    data_sram_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || data_sram_en !== 1'b0 || load_data !== 32'h0) begin
        errors++;
        $display("FAIL stray_ready%0d: rv=%b en=%b ld=%h expected 0 0 0", i, result_valid,
                 data_sram_en, load_data);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    run_access("b2b_lw", 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h0BAD_F00D, 1, 0,
               4'b0000, 32'h0, 32'h0BAD_F00D, 1'b0, 2);
    run_access("b2b_sb", 1'b1, 2'd0, 1'b0, 32'h501, 32'h0000_007E, 32'h0, 3, 1,
               4'b0010, 32'h7E7E_7E7E, 32'h0, 1'b0, 4);
    run_access("b2b_lh", 1'b0, 2'd1, 1'b0, 32'h502, 32'h0, 32'h9ABC_0000, 1, 0,
               4'b0000, 32'h0, 32'h0000_9ABC, 1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_wait_and_hold();
    test_timeout();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
